rom_download_packer: RTL and testbench

- Sits between the HPS ioctl download stream and the SDRAM controller's request port.
- Packs sequential 8-bit ROM download bytes into 32-bit little-endian words and buffers them in a small FIFO.
- Issues SDRAM writes using the controller's req/ack handshake, so the game core's ROM regions are populated before reset is released.
- Flags completion once every byte has been committed to SDRAM.

---
 rtl/rom_download_packer.sv | 169 ++++++++++++++++
 tb/tb_rom_download_packer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_download_packer.sv
// Packs ioctl download bytes into 32-bit little-endian words and writes them to SDRAM through a small FIFO.
// Lane-3 strobe to sdram_req is 2 cycles; ioctl_wait stalls the HPS at FIFO_DEPTH-1 words, and the SDRAM side is one req/ack per word.
module rom_download_packer #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [22:0] BASE_ADDR  = 23'h000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [19:0] ioctl_addr,
  input  logic [7:0]  ioctl_data,
  output logic        ioctl_wait,
  output logic [22:0] sdram_addr,
  output logic [31:0] sdram_data,
  output logic        sdram_we,
  output logic        sdram_req,
  input  logic        sdram_ack,
  output logic        busy,
  output logic        done
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] WAIT_TH = CW'(FIFO_DEPTH - 1);

  typedef struct packed {
    logic [22:0] addr;
    logic [31:0] data;
  } entry_t;

  typedef enum logic {IDLE, REQ} state_t;

  logic [31:0]   acc, acc_next, merged_acc;
  logic [3:0]    mask, mask_next, merged_mask;
  logic [17:0]   idx, idx_next, widx;
  logic [1:0]    lane;
  logic          discont;
  entry_t        p0_dat, p1_dat, held_word, new_word, head;
  logic          p0_vld, p1_vld, acc0, acc1, drop, pop;
  logic [1:0]    n_push;
  entry_t        mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, wr_ptr_1, rd_ptr;
  logic [CW-1:0] count, free;
  logic          overflow, busy_q;
  state_t        state, state_next;

  function automatic logic [22:0] word_addr(input logic [17:0] wi);
    return BASE_ADDR + {4'b0000, wi, 1'b0};
  endfunction

  assign lane      = ioctl_addr[1:0];
  assign widx      = ioctl_addr[19:2];
  assign held_word = '{addr: word_addr(idx), data: acc};
  assign new_word  = '{addr: word_addr(widx), data: merged_acc};

  // A byte from a different word flushes the held partial first; a lane-3 byte may then complete a second word in the same cycle.
  always_comb begin
    discont     = ioctl_wr && (mask != 4'd0) && (widx != idx);
    merged_acc  = discont ? 32'd0 : acc;
    merged_mask = discont ? 4'd0 : mask;
    merged_acc[{lane, 3'b000} +: 8] = ioctl_data;
    merged_mask[lane] = 1'b1;
    p0_vld    = 1'b0;
    p0_dat    = '0;
    p1_vld    = 1'b0;
    p1_dat    = '0;
    acc_next  = acc;
    mask_next = mask;
    idx_next  = idx;
    if (ioctl_wr) begin
      if (discont) begin
        p0_vld = 1'b1;
        p0_dat = held_word;
      end
      if (lane == 2'd3) begin
        if (discont) begin
          p1_vld = 1'b1;
          p1_dat = new_word;
        end else begin
          p0_vld = 1'b1;
          p0_dat = new_word;
        end
        acc_next  = 32'd0;
        mask_next = 4'd0;
      end else begin
        acc_next  = merged_acc;
        mask_next = merged_mask;
        idx_next  = widx;
      end
    end else if (!ioctl_download && (mask != 4'd0)) begin
      p0_vld    = 1'b1;
      p0_dat    = held_word;
      acc_next  = 32'd0;
      mask_next = 4'd0;
    end
  end

  assign free     = DEPTH_C - count;
  assign acc0     = p0_vld && (free != '0);
  assign acc1     = p1_vld && (free >= CW'(2));
  assign n_push   = {1'b0, acc0} + {1'b0, acc1};
  assign drop     = (p0_vld && !acc0) || (p1_vld && !acc1);
  assign pop      = (state == REQ) && sdram_ack;
  assign wr_ptr_1 = wr_ptr + PW'(1);
  assign head     = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc      <= '0;
      mask     <= '0;
      idx      <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      acc    <= acc_next;
      mask   <= mask_next;
      idx    <= idx_next;
      wr_ptr <= wr_ptr + PW'(n_push);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count  <= count + CW'(n_push) - CW'(pop);
      if (drop) overflow <= 1'b1;
      busy_q <= busy;
    end
  end

  always_ff @(posedge clk) begin
    if (acc0) mem[wr_ptr]   <= p0_dat;
    if (acc1) mem[wr_ptr_1] <= p1_dat;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (count != '0) state_next = REQ;
      REQ:     if (sdram_ack)   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sdram_addr <= '0;
      sdram_data <= '0;
    end else if (state == IDLE && count != '0) begin
      sdram_addr <= head.addr;
      sdram_data <= head.data;
    end
  end

  always_comb begin
    sdram_req = (state == REQ);
    sdram_we  = (state == REQ);
  end

  assign ioctl_wait = (count >= WAIT_TH);
  assign busy = reset_n & (ioctl_download | (mask != 4'd0) | (count != '0) | (state != IDLE) | overflow);
  assign done = busy_q & ~busy;

endmodule

// File: tb/tb_rom_download_packer.sv
// Directed bench for rom_download_packer: ROM bytes in, checks SDRAM writes, stall, done and reset behaviour.
module tb_rom_download_packer;
  localparam logic [22:0] BASE = 23'h000100;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ioctl_download, ioctl_wr;
  logic [19:0] ioctl_addr;
  logic [7:0]  ioctl_data;
  logic        ioctl_wait;
  logic [22:0] sdram_addr;
  logic [31:0] sdram_data;
  logic        sdram_we, sdram_req, sdram_ack, busy, done;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int ack_delay = 0;
  int ack_w = 0;
  logic ack_en = 1'b0;
  logic ack_force = 1'b0;
  logic stray_ack = 1'b0;
  logic [22:0] wa_q[$];
  logic [31:0] wd_q[$];

  always #5 clk = ~clk;

  rom_download_packer #(.FIFO_DEPTH(4), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset_n(reset_n),
    .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wait(ioctl_wait),
    .sdram_addr(sdram_addr), .sdram_data(sdram_data), .sdram_we(sdram_we),
    .sdram_req(sdram_req), .sdram_ack(sdram_ack), .busy(busy), .done(done)
  );

  // One clock: plays the SDRAM controller, then samples 1 ns after the edge.
  task automatic step();
    sdram_ack = 1'b0;
    if (ack_force || (ack_en && sdram_req && ack_w >= ack_delay)) begin
      sdram_ack = 1'b1;
      wa_q.push_back(sdram_addr);
      wd_q.push_back(sdram_data);
      ack_w = 0;
      ack_force = 1'b0;
    end else if (stray_ack) begin
      sdram_ack = 1'b1;
      stray_ack = 1'b0;
    end else if (ack_en && sdram_req) begin
      ack_w++;
    end
    @(posedge clk);
    #1;
    if (done) done_cnt++;
  endtask

  task automatic write_byte(input logic [19:0] a, input logic [7:0] d);
    int g = 0;
    while (ioctl_wait && g < 200) begin
      step();
      g++;
    end
    total++;
    if (ioctl_wait !== 1'b0) begin
      bad++;
      $display("FAIL write_byte_stall addr=%0h: ioctl_wait=%b required 0", a, ioctl_wait);
    end
    ioctl_addr = a;
    ioctl_data = d;
    ioctl_wr = 1'b1;
    step();
    ioctl_wr = 1'b0;
  endtask

  task automatic wait_idle();
    int g = 0;
    while (busy && g < 500) begin
      step();
      g++;
    end
    repeat (3) step();
  endtask

  task automatic start_test(input int delay, input logic en);
    wa_q.delete();
    wd_q.delete();
    done_cnt = 0;
    ack_delay = delay;
    ack_w = 0;
    ack_en = en;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    ioctl_download = 1'b0;
    ioctl_wr = 1'b0;
    ioctl_addr = '0;
    ioctl_data = '0;
    sdram_ack = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    total += 7;
    if (sdram_req !== 1'b0)  begin bad++; $display("FAIL rst_req got=%b want=0", sdram_req); end
    if (sdram_we !== 1'b0)   begin bad++; $display("FAIL rst_we got=%b want=0", sdram_we); end
    if (ioctl_wait !== 1'b0) begin bad++; $display("FAIL rst_wait got=%b want=0", ioctl_wait); end
    if (busy !== 1'b0)       begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
    if (done !== 1'b0)       begin bad++; $display("FAIL rst_done got=%b want=0", done); end
    if (sdram_addr !== 23'h0) begin bad++; $display("FAIL rst_addr got=%h want=0", sdram_addr); end
    if (sdram_data !== 32'h0) begin bad++; $display("FAIL rst_data got=%h want=0", sdram_data); end
    reset_n = 1'b1;
    step();
    step();
    total++;
    if (busy !== 1'b0 || sdram_req !== 1'b0) begin
      bad++;
      $display("FAIL rst_release busy=%b req=%b want 0/0", busy, sdram_req);
    end
  endtask

  task automatic test_aligned();
    start_test(3, 1'b1);
    ioctl_download = 1'b1;
    write_byte(20'd0, 8'h11);
    write_byte(20'd1, 8'h22);
    write_byte(20'd2, 8'h33);
    write_byte(20'd3, 8'h44);
    total++;
    if (sdram_req !== 1'b0) begin bad++; $display("FAIL aligned_lat_n1 req=%b want 0", sdram_req); end
    step();
    total += 3;
    if (sdram_req !== 1'b1) begin bad++; $display("FAIL aligned_lat_n2 req=%b want 1", sdram_req); end
    if (sdram_addr !== BASE) begin bad++; $display("FAIL aligned_req_addr got=%h want=%h", sdram_addr, BASE); end
    if (sdram_data !== 32'h44332211) begin bad++; $display("FAIL aligned_req_data got=%h want=44332211", sdram_data); end
    ioctl_download = 1'b0;
    wait_idle();
    total += 4;
    if (wa_q.size() != 1) begin bad++; $display("FAIL aligned_count got=%0d want=1", wa_q.size()); end
    if (wd_q[0] !== 32'h44332211) begin bad++; $display("FAIL aligned_data got=%h want=44332211", wd_q[0]); end
    if (done_cnt != 1) begin bad++; $display("FAIL aligned_done got=%0d want=1", done_cnt); end
    if (busy !== 1'b0) begin bad++; $display("FAIL aligned_busy got=%b want=0", busy); end
  endtask

  task automatic test_partial_tail();
    start_test(1, 1'b1);
    ioctl_download = 1'b1;
    for (int i = 0; i < 6; i++) write_byte(20'(i), 8'hA0 + 8'(i));
    ioctl_download = 1'b0;
    wait_idle();
    total += 6;
    if (wa_q.size() != 2) begin bad++; $display("FAIL tail_count got=%0d want=2", wa_q.size()); end
    if (wa_q[0] !== BASE) begin bad++; $display("FAIL tail_addr0 got=%h want=%h", wa_q[0], BASE); end
    if (wd_q[0] !== 32'hA3A2A1A0) begin bad++; $display("FAIL tail_data0 got=%h want=A3A2A1A0", wd_q[0]); end
    if (wa_q[1] !== BASE + 23'd2) begin bad++; $display("FAIL tail_addr1 got=%h want=%h", wa_q[1], BASE + 23'd2); end
    if (wd_q[1] !== 32'h0000A5A4) begin bad++; $display("FAIL tail_data1 got=%h want=0000A5A4", wd_q[1]); end
    if (done_cnt != 1) begin bad++; $display("FAIL tail_done got=%0d want=1", done_cnt); end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_d [4] = '{32'h13121110, 32'h17161514, 32'h1B1A1918, 32'h1F1E1D1C};
    start_test(0, 1'b0);
    ioctl_download = 1'b1;
    for (int i = 0; i < 8; i++) write_byte(20'(i), 8'h10 + 8'(i));
    total++;
    if (ioctl_wait !== 1'b0) begin bad++; $display("FAIL bp_wait_2words got=%b want=0", ioctl_wait); end
    for (int i = 8; i < 12; i++) write_byte(20'(i), 8'h10 + 8'(i));
    total += 3;
    if (ioctl_wait !== 1'b1) begin bad++; $display("FAIL bp_wait_3words got=%b want=1", ioctl_wait); end
    if (sdram_req !== 1'b1) begin bad++; $display("FAIL bp_req_held got=%b want=1", sdram_req); end
    if (wa_q.size() != 0) begin bad++; $display("FAIL bp_no_early_write got=%0d want=0", wa_q.size()); end
    ack_en = 1'b1;
    for (int i = 12; i < 16; i++) write_byte(20'(i), 8'h10 + 8'(i));
    ioctl_download = 1'b0;
    wait_idle();
    total += 3;
    if (wa_q.size() != 4) begin bad++; $display("FAIL bp_count got=%0d want=4", wa_q.size()); end
    if (busy !== 1'b0) begin bad++; $display("FAIL bp_busy got=%b want=0", busy); end
    if (done_cnt != 1) begin bad++; $display("FAIL bp_done got=%0d want=1", done_cnt); end
    for (int k = 0; k < 4 && k < wa_q.size(); k++) begin
      total++;
      if (wa_q[k] !== BASE + 23'(2 * k) || wd_q[k] !== exp_d[k]) begin
        bad++;
        $display("FAIL bp_word%0d got=%h/%h want=%h/%h", k, wa_q[k], wd_q[k], BASE + 23'(2 * k), exp_d[k]);
      end
    end
  endtask

  task automatic test_discontinuity();
    start_test(1, 1'b1);
    ioctl_download = 1'b1;
    write_byte(20'd0, 8'h55);
    write_byte(20'd1, 8'h66);
    write_byte(20'd8, 8'h77);
    ioctl_download = 1'b0;
    wait_idle();
    total += 5;
    if (wa_q.size() != 2) begin bad++; $display("FAIL disc_count got=%0d want=2", wa_q.size()); end
    if (wa_q[0] !== BASE || wd_q[0] !== 32'h00006655) begin
      bad++; $display("FAIL disc_word0 got=%h/%h want=%h/00006655", wa_q[0], wd_q[0], BASE);
    end
    if (wa_q[1] !== BASE + 23'd4) begin bad++; $display("FAIL disc_addr1 got=%h want=%h", wa_q[1], BASE + 23'd4); end
    if (wd_q[1] !== 32'h00000077) begin bad++; $display("FAIL disc_data1 got=%h want=00000077", wd_q[1]); end
    if (done_cnt != 1) begin bad++; $display("FAIL disc_done got=%0d want=1", done_cnt); end
  endtask

  task automatic test_reset_mid();
    logic saw_req;
    start_test(0, 1'b0);
    ioctl_download = 1'b1;
    for (int i = 0; i < 12; i++) write_byte(20'(i), 8'h30 + 8'(i));
    total += 2;
    if (sdram_req !== 1'b1) begin bad++; $display("FAIL rmid_pre_req got=%b want=1", sdram_req); end
    if (ioctl_wait !== 1'b1) begin bad++; $display("FAIL rmid_pre_wait got=%b want=1", ioctl_wait); end
    reset_n = 1'b0;
    #1;
    total += 4;
    if (sdram_req !== 1'b0) begin bad++; $display("FAIL rmid_req got=%b want=0", sdram_req); end
    if (sdram_we !== 1'b0) begin bad++; $display("FAIL rmid_we got=%b want=0", sdram_we); end
    if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b want=0", busy); end
    if (ioctl_wait !== 1'b0) begin bad++; $display("FAIL rmid_wait got=%b want=0", ioctl_wait); end
    @(posedge clk);
    @(posedge clk);
    #1;
    ioctl_download = 1'b0;
    reset_n = 1'b1;
    ack_en = 1'b1;
    saw_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      saw_req = saw_req | sdram_req;
    end
    total += 3;
    if (saw_req !== 1'b0) begin bad++; $display("FAIL rmid_no_req got=%b want=0", saw_req); end
    if (wa_q.size() != 0) begin bad++; $display("FAIL rmid_no_write got=%0d want=0", wa_q.size()); end
    if (done_cnt != 0) begin bad++; $display("FAIL rmid_done got=%0d want=0", done_cnt); end
    ioctl_download = 1'b1;
    for (int i = 0; i < 4; i++) write_byte(20'(i), 8'hC0 + 8'(i));
    ioctl_download = 1'b0;
    wait_idle();
    total++;
    if (wa_q.size() != 1 || wa_q[0] !== BASE || wd_q[0] !== 32'hC3C2C1C0) begin
      bad++; $display("FAIL rmid_after got n=%0d %h/%h want 1 %h/C3C2C1C0", wa_q.size(), wa_q[0], wd_q[0], BASE);
    end
  endtask

  task automatic test_simul_push_pop();
    int g = 0;
    start_test(0, 1'b0);
    ioctl_download = 1'b1;
    for (int i = 0; i < 4; i++) write_byte(20'(i), 8'h01 + 8'(i));
    while (!sdram_req && g < 10) begin step(); g++; end
    for (int i = 4; i < 7; i++) write_byte(20'(i), 8'h01 + 8'(i));
    total++;
    if (sdram_req !== 1'b1 || sdram_addr !== BASE) begin
      bad++; $display("FAIL pp_first_req req=%b addr=%h want 1/%h", sdram_req, sdram_addr, BASE);
    end
    ioctl_addr = 20'd7;
    ioctl_data = 8'h08;
    ioctl_wr = 1'b1;
    ack_force = 1'b1;
    step();
    ioctl_wr = 1'b0;
    total += 2;
    if (sdram_req !== 1'b0) begin bad++; $display("FAIL pp_req_drop got=%b want=0", sdram_req); end
    if (ioctl_wait !== 1'b0) begin bad++; $display("FAIL pp_wait got=%b want=0", ioctl_wait); end
    stray_ack = 1'b1;
    step();
    total += 3;
    if (sdram_req !== 1'b1) begin bad++; $display("FAIL pp_reissue got=%b want=1", sdram_req); end
    if (sdram_addr !== BASE + 23'd2) begin bad++; $display("FAIL pp_addr got=%h want=%h", sdram_addr, BASE + 23'd2); end
    if (sdram_data !== 32'h08070605) begin bad++; $display("FAIL pp_data got=%h want=08070605", sdram_data); end
    ack_en = 1'b1;
    ioctl_download = 1'b0;
    wait_idle();
    total += 3;
    if (wa_q.size() != 2) begin bad++; $display("FAIL pp_count got=%0d want=2", wa_q.size()); end
    if (wd_q[0] !== 32'h04030201) begin bad++; $display("FAIL pp_word0 got=%h want=04030201", wd_q[0]); end
    if (done_cnt != 1) begin bad++; $display("FAIL pp_done got=%0d want=1", done_cnt); end
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_partial_tail();
    test_backpressure();
    test_discontinuity();
    test_reset_mid();
    test_simul_push_pop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
